// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI byte engine between two requesters with round-robin grant
// and owns chip-select setup/gap/hold/idle timing. Optional byte watchdog: SPI_XFER_TIMEOUT_EN.
module spi_xfer_arbiter #(
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 1,
    parameter int CS_HOLD  = 1,
    parameter int CS_IDLE  = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic             i2c_wb_clk_i,
    input  logic             i2c_wb_rst_i,
    input  logic [1:0]       req_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic [LEN_W-1:0] len1_i,
    input  logic [7:0]       tx0_i,
    input  logic [7:0]       tx1_i,
    output logic [1:0]       gnt_o,
    output logic             byte_take_o,
    output logic [7:0]       rx_data_o,
    output logic [1:0]       rx_valid_o,
    output logic [1:0]       cs_n_o,
    output logic             spi_start_o,
    output logic [7:0]       spi_tx_o,
    input  logic             spi_done_i,
    input  logic [7:0]       spi_rx_i,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_GAP     = 3'd4,
        S_HOLD    = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    localparam logic [15:0] SETUP_LD = 16'(CS_SETUP);
    localparam logic [15:0] GAP_LD   = 16'(CS_GAP);
    localparam logic [15:0] HOLD_LD  = 16'(CS_HOLD);
    // RELEASE and the deciding IDLE cycle already keep CS high for two cycles.
    localparam logic [15:0] IDLE_LD  = 16'((CS_IDLE > 2) ? (CS_IDLE - 2) : 0);

    state_t           state_reg, state_next;
    logic [15:0]      cnt_reg, cnt_next;
    logic [15:0]      idle_reg, idle_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic             last_reg, last_next;
    logic [7:0]       rx_data_reg;
    logic [1:0]       rx_valid_reg;
    logic             win;
    logic [LEN_W-1:0] win_len;
    logic             timeout;

`ifdef SPI_XFER_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'((TIMEOUT > 1) ? (TIMEOUT - 1) : 0);

    logic [15:0] wd_reg, wd_next;
    logic        err_reg;

    // wd_reg counts cycles since the byte's START, so expiry lands TIMEOUT cycles after it.
    assign timeout = (state_reg == S_WAIT) && !spi_done_i && (wd_reg >= TO_LIM);

    always_comb begin
        wd_next = wd_reg;
        if (state_reg == S_START) begin
            wd_next = 16'd1;
        end else if (state_reg == S_WAIT && wd_reg != 16'hFFFF) begin
            wd_next = wd_reg + 16'd1;
        end
    end

    always_ff @(posedge i2c_wb_clk_i or posedge i2c_wb_rst_i) begin
        if (i2c_wb_rst_i) begin
            wd_reg  <= 16'd0;
            err_reg <= 1'b0;
        end else begin
            wd_reg  <= wd_next;
            err_reg <= timeout;
        end
    end

    assign err_o = err_reg;
`else
    assign timeout = 1'b0;
    // Constant low; the comparison only keeps TIMEOUT referenced in this build.
    assign err_o   = (TIMEOUT < 0);
`endif

    // Round-robin pick: a sole requester wins, a tie goes to the one not granted last.
    always_comb begin
        if (req_i == 2'b11) begin
            win = ~last_reg;
        end else begin
            win = req_i[1];
        end
        win_len = win ? len1_i : len0_i;
    end

    // State register
    always_ff @(posedge i2c_wb_clk_i or posedge i2c_wb_rst_i) begin
        if (i2c_wb_rst_i) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 16'd0;
            idle_reg     <= 16'd0;
            rem_reg      <= '0;
            gnt_reg      <= 2'b00;
            last_reg     <= 1'b1;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 2'b00;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idle_reg     <= idle_next;
            rem_reg      <= rem_next;
            gnt_reg      <= gnt_next;
            last_reg     <= last_next;
            rx_valid_reg <= (state_reg == S_WAIT && spi_done_i) ? gnt_reg : 2'b00;
            if (state_reg == S_WAIT && spi_done_i) begin
                rx_data_reg <= spi_rx_i;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idle_next  = idle_reg;
        rem_next   = rem_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (idle_reg != 16'd0) begin
                    idle_next = idle_reg - 16'd1;
                end else if (req_i != 2'b00) begin
                    gnt_next  = win ? 2'b10 : 2'b01;
                    last_next = win;
                    rem_next  = win_len;
                    if (win_len == '0) begin
                        if (CS_HOLD == 0) begin
                            state_next = S_RELEASE;
                        end else begin
                            state_next = S_HOLD;
                            cnt_next   = HOLD_LD;
                        end
                    end else if (CS_SETUP == 0) begin
                        state_next = S_START;
                    end else begin
                        state_next = S_SETUP;
                        cnt_next   = SETUP_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_reg <= 16'd1) begin
                    state_next = S_START;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            S_START: begin
                rem_next   = (rem_reg != '0) ? rem_reg - 1'b1 : '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (spi_done_i && rem_reg != '0) begin
                    if (CS_GAP == 0) begin
                        state_next = S_START;
                    end else begin
                        state_next = S_GAP;
                        cnt_next   = GAP_LD;
                    end
                end else if (spi_done_i || timeout) begin
                    // Last byte done, or watchdog expiry abandons the rest.
                    if (CS_HOLD == 0) begin
                        state_next = S_RELEASE;
                    end else begin
                        state_next = S_HOLD;
                        cnt_next   = HOLD_LD;
                    end
                end
            end
            S_GAP: begin
                if (cnt_reg <= 16'd1) begin
                    state_next = S_START;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_reg <= 16'd1) begin
                    state_next = S_RELEASE;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            S_RELEASE: begin
                gnt_next   = 2'b00;
                idle_next  = IDLE_LD;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                gnt_next   = 2'b00;
            end
        endcase
    end

    // Output decode; grant and CS are only visible while a transaction owns the bus.
    always_comb begin
        gnt_o       = 2'b00;
        spi_start_o = 1'b0;
        byte_take_o = 1'b0;
        spi_tx_o    = 8'h00;
        busy_o      = (state_reg != S_IDLE);
        unique case (state_reg)
            S_SETUP, S_WAIT, S_GAP, S_HOLD: begin
                gnt_o = gnt_reg;
            end
            S_START: begin
                gnt_o       = gnt_reg;
                spi_start_o = 1'b1;
                byte_take_o = 1'b1;
                spi_tx_o    = gnt_reg[1] ? tx1_i : tx0_i;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cs
            assign cs_n_o[gi] = ~gnt_o[gi];
        end
    endgenerate

    assign rx_data_o  = rx_data_reg;
    assign rx_valid_o = rx_valid_reg;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed stimulus with a scoreboard of expected rx bytes and a
// behavioural SPI byte engine answering each start 4 cycles later.
module tb_spi_xfer_arbiter;

    localparam int LEN_W    = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 1;
    localparam int CS_HOLD  = 1;
    localparam int CS_IDLE  = 2;
    localparam int TIMEOUT  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [LEN_W-1:0] len0 = '0;
    logic [LEN_W-1:0] len1 = '0;
    logic [7:0]       tx0 = 8'h00;
    logic [7:0]       tx1 = 8'h00;
    logic [1:0]       gnt_o;
    logic             byte_take_o;
    logic [7:0]       rx_data_o;
    logic [1:0]       rx_valid_o;
    logic [1:0]       cs_n_o;
    logic             spi_start_o;
    logic [7:0]       spi_tx_o;
    logic             spi_done = 1'b0;
    logic [7:0]       spi_rx = 8'h00;
    logic             busy_o;
    logic             err_o;

    spi_xfer_arbiter #(
        .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP),
        .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .i2c_wb_clk_i(clk),
        .i2c_wb_rst_i(rst),
        .req_i(req),
        .len0_i(len0),
        .len1_i(len1),
        .tx0_i(tx0),
        .tx1_i(tx1),
        .gnt_o(gnt_o),
        .byte_take_o(byte_take_o),
        .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o),
        .cs_n_o(cs_n_o),
        .spi_start_o(spi_start_o),
        .spi_tx_o(spi_tx_o),
        .spi_done_i(spi_done),
        .spi_rx_i(spi_rx),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] data;
    } rx_t;

    rx_t        sb_q[$];
    logic [7:0] eng_q[$];
    bit         eng_mute = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         start_count = 0;
    int         rxv_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 100) begin
            tick();
            n++;
        end
        check(name, busy_o, 1'b0);
    endtask

    // Byte engine: done with the next queued rx byte 4 cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start_o && !eng_mute && !rst) begin
                repeat (4) @(posedge clk);
                #1;
                spi_done = 1'b1;
                spi_rx   = (eng_q.size() != 0) ? eng_q.pop_front() : 8'h00;
                @(posedge clk);
                #1;
                spi_done = 1'b0;
                spi_rx   = 8'h00;
            end
        end
    end

    // Monitor: per-cycle invariants and scoreboard pop on every rx_valid_o pulse.
    initial begin
        rx_t e;
        forever begin
            @(negedge clk);
            if (spi_start_o) start_count++;
            if (cs_n_o == 2'b00) begin
                checks++;
                failures++;
                $display("FAIL cs_both_low actual=%0b required=not 00 (cycle %0d)", cs_n_o, cyc);
            end
            if (gnt_o == 2'b11) begin
                checks++;
                failures++;
                $display("FAIL gnt_two_hot actual=%0b required=one-hot (cycle %0d)", gnt_o, cyc);
            end
            if (rx_valid_o != 2'b00) begin
                rxv_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0b/%0h required=none (cycle %0d)",
                             rx_valid_o, rx_data_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("rx_who", rx_valid_o, e.who);
                    check("rx_data", rx_data_o, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int s0, r0_n, g0, r0, g1, low;
        bit raised, gap;
        logic [1:0] next_gnt;

        // Reset state
        repeat (3) tick();
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_cs", cs_n_o, 2'b11);
        check("rst_start", spi_start_o, 1'b0);
        check("rst_tx", spi_tx_o, 8'h00);
        check("rst_take", byte_take_o, 1'b0);
        check("rst_rxv", rx_valid_o, 2'b00);
        check("rst_rxd", rx_data_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // T1: requester 0, two bytes
        req = 2'b01; len0 = 4'd2; tx0 = 8'h11;
        eng_q.push_back(8'hA5); eng_q.push_back(8'h3C);
        sb_q.push_back('{2'b01, 8'hA5}); sb_q.push_back('{2'b01, 8'h3C});
        tick();
        check("t1_cs_low", cs_n_o, 2'b10);
        check("t1_gnt", gnt_o, 2'b01);
        req = 2'b00;
        tick();
        check("t1_setup_nostart", spi_start_o, 1'b0);
        for (int k = 3; k <= 17; k++) begin
            tick();
            check("t1_start", spi_start_o, (k == 3 || k == 9));
            check("t1_cs", cs_n_o, (k <= 14) ? 2'b10 : 2'b11);
            check("t1_busy", busy_o, (k <= 15));
            if (k == 3) begin
                check("t1_tx_a", spi_tx_o, 8'h11);
                check("t1_take", byte_take_o, 1'b1);
                tx0 = 8'h22;
            end
            if (k == 9) check("t1_tx_b", spi_tx_o, 8'h22);
        end

        // T2: both request from reset, one byte each
        rst = 1'b1;
        req = 2'b11; len0 = 4'd1; len1 = 4'd1; tx0 = 8'h40; tx1 = 8'h41;
        eng_q.push_back(8'h90); eng_q.push_back(8'h91);
        sb_q.push_back('{2'b01, 8'h90}); sb_q.push_back('{2'b10, 8'h91});
        tick();
        rst = 1'b0;
        g0 = -1; r0 = -1; g1 = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (g0 < 0 && gnt_o == 2'b01) g0 = cyc;
            if (g0 >= 0 && r0 < 0 && cs_n_o[0]) r0 = cyc;
            if (g1 < 0 && gnt_o == 2'b10) begin
                g1 = cyc;
                req = 2'b00;
            end
            if (g1 >= 0 && !busy_o) break;
        end
        check("t2_first_grant_0", (g0 >= 0 && g1 >= 0 && g0 < g1), 1'b1);
        check("t2_cs_idle_gap", (r0 >= 0 && g1 >= 0 && (g1 - r0) >= CS_IDLE), 1'b1);
        wait_idle("t2_idle");
        repeat (3) tick();

        // T3: requester 1 holds req, requester 0 joins mid-transaction
        req = 2'b10; len0 = 4'd1; len1 = 4'd1; tx0 = 8'h50; tx1 = 8'h51;
        eng_q.push_back(8'hB1); eng_q.push_back(8'hB0);
        sb_q.push_back('{2'b10, 8'hB1}); sb_q.push_back('{2'b01, 8'hB0});
        raised = 1'b0; gap = 1'b0; next_gnt = 2'b00;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (!raised && gnt_o == 2'b10) begin
                req = 2'b11;
                raised = 1'b1;
            end else if (raised && !gap && gnt_o == 2'b00) begin
                gap = 1'b1;
            end else if (gap && gnt_o != 2'b00) begin
                next_gnt = gnt_o;
                req = 2'b00;
                break;
            end
        end
        check("t3_next_grant", next_gnt, 2'b01);
        req = 2'b00;
        wait_idle("t3_idle");
        repeat (3) tick();

        // T4: zero-length transaction on requester 1
        s0 = start_count; r0_n = rxv_count; low = 0;
        req = 2'b10; len1 = 4'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!cs_n_o[1]) low++;
            if (gnt_o == 2'b10) req = 2'b00;
        end
        check("t4_starts", start_count - s0, 0);
        check("t4_rxv", rxv_count - r0_n, 0);
        check("t4_cs_pulse", (low >= 1 && low <= CS_SETUP + CS_HOLD), 1'b1);
        check("t4_idle", busy_o, 1'b0);

        // T5: reset during WAIT of byte 2 of 3
        s0 = start_count;
        req = 2'b01; len0 = 4'd3; tx0 = 8'h60;
        eng_q.push_back(8'h61); eng_q.push_back(8'h62); eng_q.push_back(8'h63);
        sb_q.push_back('{2'b01, 8'h61});
        for (int i = 0; i < 60; i++) begin
            tick();
            if (gnt_o == 2'b01) req = 2'b00;
            if (start_count - s0 >= 2) break;
        end
        check("t5_two_starts", start_count - s0, 2);
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_cs", cs_n_o, 2'b11);
        check("t5_rst_gnt", gnt_o, 2'b00);
        check("t5_rst_busy", busy_o, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_rxv", rx_valid_o, 2'b00);
        end
        eng_q.delete();
        check("t5_idle", busy_o, 1'b0);

`ifdef SPI_XFER_TIMEOUT_EN
        // T6: engine never answers
        eng_mute = 1'b1;
        s0 = start_count;
        req = 2'b01; len0 = 4'd2;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt_o == 2'b01) req = 2'b00;
            if (start_count - s0 >= 1) break;
        end
        for (int k = 1; k <= 12; k++) begin
            check("t6_err", err_o, (k == TIMEOUT));
            tick();
        end
        check("t6_abandoned", start_count - s0, 1);
        wait_idle("t6_idle");
        eng_mute = 1'b0;
        req = 2'b10; len1 = 4'd1; tx1 = 8'h70;
        eng_q.push_back(8'h77);
        sb_q.push_back('{2'b10, 8'h77});
        next_gnt = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt_o != 2'b00) begin
                next_gnt = gnt_o;
                break;
            end
        end
        check("t6_regrant", next_gnt, 2'b10);
        req = 2'b00;
        wait_idle("t6_final_idle");
`endif

        repeat (10) tick();
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
